fma16_sched: RTL and testbench

Round-robin scheduler that shares one combinational `fma16` datapath among `NREQ` requesters. It accepts tagged operation requests over valid/ready and decodes a 3-bit opcode into the `mul/add/negr/negz` controls. It drives the datapath from an issue register, tracks in-flight operations through a `LAT`-deep tag pipeline, and returns in-order results through a credit-protected response FIFO. It sits between the core's FP issue logic and the `fma16` instance.

---
 rtl/fma16_pkg.sv | 51 +++++
 rtl/fma16_sched_rr_arb.sv | 43 ++++
 rtl/fma16_sched.sv | 187 ++++++++++++++++++
 tb/tb_fma16_sched.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma16_pkg.sv
// Shared types for the fma16 scheduler: opcode enum, decoded control struct,
// decode helpers, the illegal-op quiet NaN and the round-mode encodings.
package fma16_pkg;

  typedef enum logic [2:0] {
    OP_FADD    = 3'b000,
    OP_FSUB    = 3'b001,
    OP_FMUL    = 3'b010,
    OP_FMADD   = 3'b011,
    OP_FMSUB   = 3'b100,
    OP_FNMADD  = 3'b101,
    OP_FNMSUB  = 3'b110,
    OP_ILLEGAL = 3'b111
  } fma_op_e;

  typedef struct packed {
    logic mul;
    logic add;
    logic negr;
    logic negz;
  } fma_ctrl_t;

  localparam logic [15:0] FMA16_QNAN = 16'h7E00;

  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RP  = 2'b10;
  localparam logic [1:0] RM_RN  = 2'b11;

  // Illegal opcodes decode to all-zero controls so the datapath sees a no-op.
  function automatic fma_ctrl_t fma_decode(input logic [2:0] op);
    fma_ctrl_t c;
    c = '0;
    case (fma_op_e'(op))
      OP_FADD:   c = '{mul: 1'b0, add: 1'b1, negr: 1'b0, negz: 1'b0};
      OP_FSUB:   c = '{mul: 1'b0, add: 1'b1, negr: 1'b0, negz: 1'b1};
      OP_FMUL:   c = '{mul: 1'b1, add: 1'b0, negr: 1'b0, negz: 1'b0};
      OP_FMADD:  c = '{mul: 1'b1, add: 1'b1, negr: 1'b0, negz: 1'b0};
      OP_FMSUB:  c = '{mul: 1'b1, add: 1'b1, negr: 1'b0, negz: 1'b1};
      OP_FNMADD: c = '{mul: 1'b1, add: 1'b1, negr: 1'b1, negz: 1'b0};
      OP_FNMSUB: c = '{mul: 1'b1, add: 1'b1, negr: 1'b1, negz: 1'b1};
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic logic fma_is_illegal(input logic [2:0] op);
    return op == OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/fma16_sched_rr_arb.sv
// Round-robin arbiter: first valid requester after the last accepted one wins;
// the pointer moves only when the caller reports an accept on i_advance.
module fma16_rr_arb #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         i_valid,
  input  logic                 i_advance,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] r_last;

  always_comb begin : p_grant
    int   j;
    logic found;
    j       = 0;
    found   = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(r_last) + k) % N;
      if (!found && i_valid[j]) begin
        found      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= IW'(N - 1);
    end else if (i_advance) begin
      r_last <= o_idx;
    end
  end

endmodule

// File: rtl/fma16_sched.sv
// Shares one fma16 datapath among NREQ requesters with credit-protected,
// in-order responses. Define FMA16_SCHED_PERF_EN to enable the debug counters.
module fma16_sched
  import fma16_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LAT      = 1,
  parameter int RQ_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [3*NREQ-1:0]       req_op,
  input  logic [16*NREQ-1:0]      req_x,
  input  logic [16*NREQ-1:0]      req_y,
  input  logic [16*NREQ-1:0]      req_z,
  input  logic [2*NREQ-1:0]       req_rm,
  output logic [15:0]             fma_x,
  output logic [15:0]             fma_y,
  output logic [15:0]             fma_z,
  output logic                    fma_mul,
  output logic                    fma_add,
  output logic                    fma_negr,
  output logic                    fma_negz,
  output logic [1:0]              fma_rm,
  input  logic [15:0]             fma_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [15:0]             rsp_result,
  output logic                    rsp_err,
  output logic [31:0]             debug
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(RQ_DEPTH);
  localparam int CW  = $clog2(RQ_DEPTH + 1);

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_credit_ok;
  logic            w_accept;
  logic [7:0]      w_inflight;
  logic [7:0]      w_pipe_cnt;
  logic            w_fin_v;
  logic [IDW-1:0]  w_fin_id;
  logic            w_fin_ill;
  logic            w_push;
  logic            w_pop;
  logic [2:0]      w_sel_op;

  logic            r_iv;
  logic [15:0]     r_x, r_y, r_z;
  logic [1:0]      r_rm;
  fma_ctrl_t       r_ctrl;
  logic [IDW-1:0]  r_id;
  logic            r_ill;

  logic [IDW+16:0] r_mem [RQ_DEPTH];
  logic [PW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_cnt;
  logic [IDW+16:0] w_head;

  fma16_rr_arb #(.N(NREQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (req_valid),
    .i_advance (w_accept),
    .o_grant   (w_grant),
    .o_idx     (w_idx)
  );

  // Every op holds a credit from accept until its response leaves the FIFO.
  assign w_inflight  = 8'(r_cnt) + 8'(r_iv) + w_pipe_cnt;
  assign w_credit_ok = w_inflight < 8'(RQ_DEPTH);
  assign req_ready   = (reset || !w_credit_ok) ? '0 : w_grant;
  assign w_accept    = |req_ready;
  assign w_sel_op    = req_op[int'(w_idx)*3 +: 3];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_iv <= 1'b0;
    end else begin
      r_iv <= w_accept;
      if (w_accept) begin
        r_x    <= req_x[int'(w_idx)*16 +: 16];
        r_y    <= req_y[int'(w_idx)*16 +: 16];
        r_z    <= req_z[int'(w_idx)*16 +: 16];
        r_rm   <= req_rm[int'(w_idx)*2 +: 2];
        r_ctrl <= fma_decode(w_sel_op);
        r_id   <= w_idx;
        r_ill  <= fma_is_illegal(w_sel_op);
      end
    end
  end

  assign fma_x    = r_iv ? r_x  : '0;
  assign fma_y    = r_iv ? r_y  : '0;
  assign fma_z    = r_iv ? r_z  : '0;
  assign fma_rm   = r_iv ? r_rm : '0;
  assign fma_mul  = r_iv & r_ctrl.mul;
  assign fma_add  = r_iv & r_ctrl.add;
  assign fma_negr = r_iv & r_ctrl.negr;
  assign fma_negz = r_iv & r_ctrl.negz;

  // Tag pipeline tracks which requester owns the result emerging from fma16.
  if (LAT == 0) begin : g_nopipe
    assign w_fin_v    = r_iv;
    assign w_fin_id   = r_id;
    assign w_fin_ill  = r_ill;
    assign w_pipe_cnt = '0;
  end else begin : g_pipe
    logic [LAT-1:0] r_pv;
    logic [LAT-1:0] r_pill;
    logic [IDW-1:0] r_pid [LAT];

    always_ff @(posedge clk) begin
      if (reset) begin
        r_pv <= '0;
      end else begin
        r_pv[0] <= r_iv;
        for (int i = 1; i < LAT; i++) r_pv[i] <= r_pv[i-1];
      end
      r_pid[0]  <= r_id;
      r_pill[0] <= r_ill;
      for (int i = 1; i < LAT; i++) begin
        r_pid[i]  <= r_pid[i-1];
        r_pill[i] <= r_pill[i-1];
      end
    end

    assign w_fin_v    = r_pv[LAT-1];
    assign w_fin_id   = r_pid[LAT-1];
    assign w_fin_ill  = r_pill[LAT-1];
    assign w_pipe_cnt = 8'($countones(r_pv));
  end

  assign w_push = w_fin_v;
  assign w_pop  = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {w_fin_id, (w_fin_ill ? FMA16_QNAN : fma_result), w_fin_ill};
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign rsp_valid  = r_cnt != '0;
  assign w_head     = r_mem[r_rp];
  assign rsp_id     = rsp_valid ? w_head[IDW+16:17] : '0;
  assign rsp_result = rsp_valid ? w_head[16:1]      : '0;
  assign rsp_err    = rsp_valid & w_head[0];

`ifdef FMA16_SCHED_PERF_EN
  logic [15:0] r_acc_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept && r_acc_cnt != 16'hFFFF) r_acc_cnt <= r_acc_cnt + 1'b1;
      if (|req_valid && !w_accept && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign debug = {r_stall_cnt, r_acc_cnt};
`else
  assign debug = '0;
`endif

endmodule

// File: tb/tb_fma16_sched.sv
// Directed bench for fma16_sched with a small integer-exact fma16 stand-in.
module tb_fma16_sched;
  import fma16_pkg::*;

  localparam int NREQ     = 4;
  localparam int LAT      = 1;
  localparam int RQ_DEPTH = 4;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [3*NREQ-1:0]    req_op;
  logic [16*NREQ-1:0]   req_x, req_y, req_z;
  logic [2*NREQ-1:0]    req_rm;
  logic [15:0]          fma_x, fma_y, fma_z;
  logic                 fma_mul, fma_add, fma_negr, fma_negz;
  logic [1:0]           fma_rm;
  logic [15:0]          fma_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [15:0]          rsp_result;
  logic                 rsp_err;
  logic [31:0]          debug;

  fma16_sched #(.NREQ(NREQ), .LAT(LAT), .RQ_DEPTH(RQ_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_z      (req_z),
    .req_rm     (req_rm),
    .fma_x      (fma_x),
    .fma_y      (fma_y),
    .fma_z      (fma_z),
    .fma_mul    (fma_mul),
    .fma_add    (fma_add),
    .fma_negr   (fma_negr),
    .fma_negz   (fma_negz),
    .fma_rm     (fma_rm),
    .fma_result (fma_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .debug      (debug)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- fma16 stand-in (exact for small integers) ----------------
  function automatic int h2i(input logic [15:0] h);
    int e, m, v;
    e = int'(h[14:10]);
    if (e == 0) return 0;
    m = 1024 + int'(h[9:0]);
    v = (e >= 25) ? (m << (e - 25)) : (m >> (25 - e));
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] i2h(input int v);
    int a, p;
    logic [15:0] h;
    a = (v < 0) ? -v : v;
    p = -1;
    for (int b = 10; b >= 0; b--) if (p < 0 && a[b]) p = b;
    if (p < 0) return 16'h0000;
    h[15]    = (v < 0);
    h[14:10] = 5'(p + 15);
    h[9:0]   = 10'((a << (10 - p)) & 32'h3FF);
    return h;
  endfunction

  always @(posedge clk) begin : fma_model
    int prod, addend, r;
    prod   = fma_mul ? h2i(fma_x) * h2i(fma_y) : h2i(fma_x);
    addend = fma_add ? (fma_negz ? -h2i(fma_z) : h2i(fma_z)) : 0;
    r      = fma_negr ? -(prod + addend) : (prod + addend);
    fma_result <= i2h(r);
  end

  // ---------------- monitor / scoreboard ----------------
  logic [18:0] rsp_q[$];
  logic [18:0] exp_q[$];
  int          acc_q[$];
  int          outstanding = 0;

  always @(negedge clk) begin
    if (reset) begin
      outstanding = 0;
    end else begin
      for (int k = 0; k < NREQ; k++)
        if (req_valid[k] && req_ready[k]) begin
          acc_q.push_back(k);
          outstanding++;
        end
      if (rsp_valid && rsp_ready) begin
        rsp_q.push_back({rsp_id, rsp_result, rsp_err});
        outstanding--;
      end
      total++;
      assert (outstanding <= RQ_DEPTH) else begin
        bad++;
        $error("FAIL overflow observed=%0d expected<=%0d", outstanding, RQ_DEPTH);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [2:0] op, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] z, input logic [1:0] rm);
    req_op[i*3 +: 3]  = op;
    req_x[i*16 +: 16] = x;
    req_y[i*16 +: 16] = y;
    req_z[i*16 +: 16] = z;
    req_rm[i*2 +: 2]  = rm;
    req_valid[i]      = 1'b1;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    acc_q.delete();
    rsp_q.delete();
  endtask

  task automatic push_exp(input int id, input logic [15:0] r, input logic e);
    exp_q.push_back({2'(id), r, e});
  endtask

  task automatic compare_rsp(input string tag);
    check({tag, "_count"}, rsp_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < rsp_q.size(); k++)
      check(tag, 32'(rsp_q[k]), 32'(exp_q[k]));
    rsp_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [3:0] ctrl();
    return {fma_mul, fma_add, fma_negr, fma_negz};
  endfunction

  logic [15:0] hx [5] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};
  int n;
  logic acc;

  initial begin
    reset = 1'b1; req_valid = '0; req_op = '0; req_x = '0; req_y = '0; req_z = '0;
    req_rm = '0; rsp_ready = 1'b0;
    req_valid = 4'b1001;

    // reset state, with requests pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp", 32'({rsp_id, rsp_result, rsp_err}), 32'h0);
    check("rst_fma_xy", {fma_x, fma_y}, 32'h0);
    check("rst_fma_ctl", 32'({fma_z, ctrl(), fma_rm}), 32'h0);
    check("rst_debug", debug, 32'h0);
    tick();
    req_valid = '0; reset = 1'b0; rsp_ready = 1'b1;
    acc_q.delete(); rsp_q.delete();

    // single fmul, latency and controls
    set_req(0, OP_FMUL, 16'h3C00, 16'h4000, 16'h0000, RM_RNE);
    @(negedge clk); check("t1_ready", 32'(req_ready), 32'h1);
    tick(); clr_req(0);
    @(negedge clk);
    check("t1_ctrl", 32'(ctrl()), 32'h8);
    check("t1_xy", {fma_x, fma_y}, 32'h3C00_4000);
    check("t1_rm", 32'(fma_rm), 32'(RM_RNE));
    @(negedge clk);
    check("t1_early_valid", 32'(rsp_valid), 32'h0);
    check("t1_idle_fma", {fma_x, fma_y}, 32'h0);
    @(negedge clk);
    check("t1_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp", 32'({rsp_id, rsp_result, rsp_err}), 32'({2'd0, 16'h4000, 1'b0}));
    tick();

    // four requesters streaming: round-robin order
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, OP_FADD, 16'h3C00, 16'h0000, 16'h3C00, RM_RNE);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) clr_req(i);
    check("t2_acc_count", acc_q.size(), 5);
    for (int k = 0; k < 5 && k < acc_q.size(); k++) check("t2_grant", acc_q[k], k % 4);
    push_exp(0, 16'h4000, 0); push_exp(1, 16'h4000, 0); push_exp(2, 16'h4000, 0);
    push_exp(3, 16'h4000, 0); push_exp(0, 16'h4000, 0);
    repeat (6) tick();
    compare_rsp("t2_rsp");

    // fmadd then fnmsub from requester 2
    set_req(2, OP_FMADD, 16'h4000, 16'h4000, 16'h3C00, RM_RNE);
    @(negedge clk); check("t3_ready1", 32'(req_ready), 32'h4);
    tick(); set_req(2, OP_FNMSUB, 16'h4000, 16'h4000, 16'h3C00, RM_RNE);
    @(negedge clk);
    check("t3_ctrl1", 32'(ctrl()), 32'hC);
    check("t3_ready2", 32'(req_ready), 32'h4);
    tick(); clr_req(2);
    @(negedge clk); check("t3_ctrl2", 32'(ctrl()), 32'hF);
    push_exp(2, 16'h4500, 0);   // 2*2+1 = 5
    push_exp(2, 16'hC200, 0);   // -(2*2-1) = -3
    repeat (5) tick();
    compare_rsp("t3_rsp");

    // illegal op then fsub from requester 1
    set_req(1, OP_ILLEGAL, 16'h4000, 16'h4000, 16'h3C00, RM_RZ);
    @(negedge clk); check("t4_ready", 32'(req_ready), 32'h2);
    tick(); set_req(1, OP_FSUB, 16'h4000, 16'h0000, 16'h3C00, RM_RZ);
    @(negedge clk); check("t4_ill_ctrl", 32'(ctrl()), 32'h0);
    tick(); clr_req(1);
    @(negedge clk); check("t4_fsub_ctrl", 32'(ctrl()), 32'h5);
    push_exp(1, FMA16_QNAN, 1);
    push_exp(1, 16'h3C00, 0);
    repeat (5) tick();
    compare_rsp("t4_rsp");

    // backpressure: credits run out, one pop frees exactly one slot
    rsp_ready = 1'b0;
    acc_q.delete(); rsp_q.delete();
    n = 0;
    set_req(0, OP_FMUL, hx[0], 16'h4000, 16'h0000, RM_RNE);
    repeat (8) begin
      @(negedge clk); acc = req_ready[0];
      tick();
      if (acc) begin
        n++;
        if (n < 5) req_x[15:0] = hx[n];
      end
    end
    check("t5_accepts", n, 4);
    @(negedge clk);
    check("t5_stalled", 32'(req_ready), 32'h0);
    check("t5_full_valid", 32'(rsp_valid), 32'h1);
    tick(); rsp_ready = 1'b1;
    @(negedge clk); check("t5_pop_cycle", 32'(req_ready), 32'h0);
    tick(); rsp_ready = 1'b0;
    @(negedge clk); check("t5_resume", 32'(req_ready), 32'h1);
    tick();
    @(negedge clk); check("t5_restall", 32'(req_ready), 32'h0);
    tick(); clr_req(0); rsp_ready = 1'b1;
    push_exp(0, 16'h4000, 0); push_exp(0, 16'h4400, 0); push_exp(0, 16'h4600, 0);
    push_exp(0, 16'h4800, 0); push_exp(0, 16'h4900, 0);
    repeat (10) tick();
    compare_rsp("t5_rsp");

    // reset with ops in flight
    rsp_ready = 1'b0;
    set_req(1, OP_FADD, 16'h3C00, 16'h0000, 16'h3C00, RM_RNE);
    repeat (3) @(posedge clk);
    #1;
    clr_req(1);
    set_req(0, OP_FMUL, 16'h3C00, 16'h4000, 16'h0000, RM_RNE);
    set_req(3, OP_FADD, 16'h3C00, 16'h0000, 16'h3C00, RM_RNE);
    reset = 1'b1;
    @(negedge clk); check("t6_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("t6_rst_valid", 32'(rsp_valid), 32'h0);
    check("t6_rst_ready2", 32'(req_ready), 32'h0);
    tick(); reset = 1'b0; rsp_ready = 1'b1;
    acc_q.delete(); rsp_q.delete();
    @(negedge clk); check("t6_grant0", 32'(req_ready), 32'h1);
    tick(); clr_req(0);
    @(negedge clk); check("t6_grant3", 32'(req_ready), 32'h8);
    tick(); clr_req(3);
    push_exp(0, 16'h4000, 0);
    push_exp(3, 16'h4000, 0);
    repeat (6) tick();
    compare_rsp("t6_rsp");
    check("end_debug", debug, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
